mac_feeder: RTL and testbench
=============================

Name: mac_feeder

Overview:
- Producer-side front end for the MAC block: the writer that fills its signal and coefficient FIFOs.
- Accepts two upstream valid/ready streams: coefficients and signal samples.
- First loads a run-time number of taps into the coefficient FIFO, then streams samples into the signal FIFO.
- Each path uses a one-entry hold register that throttles on the FIFO full flags; the block owns all FIFO write strobes.

Parameters:
- DATA_WIDTH, 32, width of coefficient and sample words.
- ADDR_LINES, 4, FIFO address width; maximum taps = 2**ADDR_LINES.
- CNT_WIDTH, 16, width of the sample write counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; begins a coefficient load; honoured only in IDLE.
- taps_i  in  ADDR_LINES+1  tap count, latched on start_i; legal range 1..2**ADDR_LINES.
- stop_i  in  1  pulse; ends streaming once buffered data has drained.
- flush_i  in  1  pulse; abort from any state.
- coeff_data_i  in  DATA_WIDTH  upstream coefficient word.
- coeff_valid_i  in  1  coefficient valid.
- coeff_ready_o  out  1  coefficient ready.
- sig_data_i  in  DATA_WIDTH  upstream sample word.
- sig_valid_i  in  1  sample valid.
- sig_ready_o  out  1  sample ready.
- coeff_fifo_o  out  DATA_WIDTH  word to the coefficient FIFO.
- coeff_wr_o  out  1  coefficient FIFO write strobe.
- full_adder_i  in  1  coefficient FIFO full.
- signal_fifo_o  out  DATA_WIDTH  word to the signal FIFO.
- signal_wr_o  out  1  signal FIFO write strobe.
- full_mul_i  in  1  signal FIFO full.
- busy_o  out  1  state is not IDLE.
- coeff_loaded_o  out  1  all taps written; held until the next start or flush.
- sample_cnt_o  out  CNT_WIDTH  number of samples written to the signal FIFO.
- err_o  out  1  sticky flag: illegal taps_i seen on start.

Behaviour:
- Reset: every register and output is 0, the FSM is in IDLE, and both hold registers are empty.
- FSM states: IDLE, LOAD, STREAM, DRAIN.
  - IDLE -> LOAD on start_i with taps_i in range; taps latched, tap counter cleared, coeff_loaded_o cleared, err_o cleared.
  - IDLE stays on start_i with taps_i = 0 or > 2**ADDR_LINES; err_o set.
  - LOAD -> STREAM on the cycle the last coefficient write occurs (tap counter reaches taps−1 with coeff_wr_o=1); coeff_loaded_o set the same edge.
  - STREAM -> DRAIN on stop_i.
  - DRAIN -> IDLE once the signal hold register is empty.
  - start_i outside IDLE is ignored.
- Hold stage (identical for each path): hold_v/hold_d registers.
  - Write strobe: wr_o = hold_v & ~full_i (combinational); FIFO data output = hold_d.
  - Ready: ready_o = path_enable & (~hold_v | ~full_i).
  - On accept (valid & ready): hold is loaded; otherwise hold_v is cleared when wr_o is asserted.
  - Sustained throughput is 1 word/cycle while not full. Latency: an accepted word appears with its write strobe the next cycle.
  - A full_i asserted while hold_v=1 holds the word stable, strobe low, until full deasserts.
- Path enables:
  - Coefficient path: enabled in LOAD only, and only while accepted count < taps; it accepts exactly taps words.
  - Signal path: enabled in STREAM only; DRAIN accepts nothing.
- sample_cnt_o: increments on each signal_wr_o, wraps modulo 2**CNT_WIDTH, cleared on start_i and flush_i.
- stop_i and a sample accepted in the same cycle: the sample is accepted, then DRAIN.
- flush_i:
  - Takes priority over all other inputs; next cycle the state is IDLE.
  - Clears hold_v, coeff_loaded_o and sample_cnt_o.
  - No write strobe is issued in the cycle after flush. err_o is preserved.
- Reset asserted mid-operation: immediate return to reset values; in-flight data is discarded.
- busy_o: registered, equal to (state != IDLE).

Decomposition:
- Shared package mac_pkg holds:
  - the FSM state encoding (feed_state_t: IDLE, LOAD, STREAM, DRAIN);
  - the DATA_WIDTH and ADDR_LINES default constants;
  - the MAX_TAPS = 2**ADDR_LINES constant.
- One sub-module, feed_hold_stage: a parameterised one-entry hold register with ready/valid in and write/full out. It is instantiated twice, once per path; the top level holds the FSM and counters.

Test Plan:
- taps_i=4, start pulse, four coefficient words 0x11..0x14 back-to-back, full low -> coeff_wr_o high 4 consecutive cycles with data 0x11..0x14; coeff_loaded_o=1 on the 4th write; state becomes STREAM.
- STREAM, samples 0xA0..0xA7 valid every cycle; full_mul_i asserted for 3 cycles during word 0xA3 -> 0xA3 held stable with signal_wr_o low; sig_ready_o low during those cycles; no loss or duplication; sample_cnt_o=8.
- start_i with taps_i=0 -> err_o=1, busy_o=0, no strobes; then start with taps_i=16 -> err_o cleared, 16 coefficients loaded.
- stop_i in the same cycle a sample is accepted while full_mul_i=1 -> DRAIN; that sample written after full drops; then IDLE with busy_o=0.
- flush_i mid-LOAD after 2 of 8 coefficients -> next cycle IDLE, coeff_wr_o=0, coeff_loaded_o=0; a fresh start with taps_i=8 loads 8 words from the counter at 0.
- rstn_i pulsed low mid-STREAM with hold_v=1 -> all outputs 0 asynchronously; no write strobe after release until a new start and load.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC feeder: FSM encoding and default sizing constants.
package mac_pkg;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_LINES_DEF = 4;
   localparam int MAX_TAPS       = 2**ADDR_LINES_DEF;

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} feed_state_t;
endpackage

// File: rtl/feed_hold_stage.sv
// One-entry hold register between an upstream valid/ready stream and a FIFO write port.
module feed_hold_stage
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  ready,
   output logic                  wr,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  full,
   output logic                  occupied
);
   logic                  hold_v;
   logic [DATA_WIDTH-1:0] hold_d;

   // A held word leaves whenever the FIFO has room, so a new word can enter the same cycle.
   assign wr       = hold_v & ~full;
   assign ready    = en & (~hold_v | ~full);
   assign out_data = hold_d;
   assign occupied = hold_v;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_v <= 1'b0;
         hold_d <= '0;
      end else if (clr) begin
         hold_v <= 1'b0;
      end else if (in_valid && ready) begin
         hold_v <= 1'b1;
         hold_d <= in_data;
      end else if (wr) begin
         hold_v <= 1'b0;
      end
   end
endmodule

// File: rtl/mac_feeder.sv
// MAC front end: loads a run-time number of coefficients, then streams samples into the signal FIFO.
module mac_feeder
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_LINES = ADDR_LINES_DEF,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic [ADDR_LINES:0]   taps_i,
   input  logic                  stop_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] coeff_data_i,
   input  logic                  coeff_valid_i,
   output logic                  coeff_ready_o,
   input  logic [DATA_WIDTH-1:0] sig_data_i,
   input  logic                  sig_valid_i,
   output logic                  sig_ready_o,
   output logic [DATA_WIDTH-1:0] coeff_fifo_o,
   output logic                  coeff_wr_o,
   input  logic                  full_adder_i,
   output logic [DATA_WIDTH-1:0] signal_fifo_o,
   output logic                  signal_wr_o,
   input  logic                  full_mul_i,
   output logic                  busy_o,
   output logic                  coeff_loaded_o,
   output logic [CNT_WIDTH-1:0]  sample_cnt_o,
   output logic                  err_o
);
   localparam logic [ADDR_LINES:0] TAPS_MAX = (ADDR_LINES+1)'(2**ADDR_LINES);

   feed_state_t           state;
   logic [ADDR_LINES:0]   taps_q;
   logic [ADDR_LINES:0]   acc_cnt;
   logic [ADDR_LINES:0]   wr_cnt;
   logic                  coeff_en;
   logic                  sig_en;
   logic                  coeff_occ;
   logic                  sig_occ;
   logic                  taps_ok;

   assign taps_ok  = (taps_i != '0) && (taps_i <= TAPS_MAX);
   // Flush wins over everything, so neither path accepts in the flush cycle.
   assign coeff_en = (state == LOAD) && (acc_cnt < taps_q) && !flush_i;
   assign sig_en   = (state == STREAM) && !flush_i;

   feed_hold_stage #(.DATA_WIDTH(DATA_WIDTH)) u_coeff_hold (
      .clk      (clk_i),
      .rstn     (rstn_i),
      .clr      (flush_i),
      .en       (coeff_en),
      .in_data  (coeff_data_i),
      .in_valid (coeff_valid_i),
      .ready    (coeff_ready_o),
      .wr       (coeff_wr_o),
      .out_data (coeff_fifo_o),
      .full     (full_adder_i),
      .occupied (coeff_occ)
   );

   feed_hold_stage #(.DATA_WIDTH(DATA_WIDTH)) u_sig_hold (
      .clk      (clk_i),
      .rstn     (rstn_i),
      .clr      (flush_i),
      .en       (sig_en),
      .in_data  (sig_data_i),
      .in_valid (sig_valid_i),
      .ready    (sig_ready_o),
      .wr       (signal_wr_o),
      .out_data (signal_fifo_o),
      .full     (full_mul_i),
      .occupied (sig_occ)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state          <= IDLE;
         busy_o         <= 1'b0;
         taps_q         <= '0;
         acc_cnt        <= '0;
         wr_cnt         <= '0;
         coeff_loaded_o <= 1'b0;
         sample_cnt_o   <= '0;
         err_o          <= 1'b0;
      end else if (flush_i) begin
         state          <= IDLE;
         busy_o         <= 1'b0;
         coeff_loaded_o <= 1'b0;
         sample_cnt_o   <= '0;
      end else begin
         if (signal_wr_o) sample_cnt_o <= sample_cnt_o + 1'b1;
         case (state)
            IDLE: begin
               if (start_i) begin
                  sample_cnt_o <= '0;
                  if (taps_ok) begin
                     state          <= LOAD;
                     busy_o         <= 1'b1;
                     taps_q         <= taps_i;
                     acc_cnt        <= '0;
                     wr_cnt         <= '0;
                     coeff_loaded_o <= 1'b0;
                     err_o          <= 1'b0;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (coeff_valid_i && coeff_ready_o) acc_cnt <= acc_cnt + 1'b1;
               if (coeff_wr_o) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == taps_q - 1'b1) begin
                     state          <= STREAM;
                     coeff_loaded_o <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (stop_i) state <= DRAIN;
            end
            DRAIN: begin
               if (!sig_occ && !coeff_occ) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: queue-based reference model plus directed and random stimulus.
module tb_mac_feeder;
   localparam int DW = 32;
   localparam int AL = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rstn_i;
   logic          start_i, stop_i, flush_i;
   logic [AL:0]   taps_i;
   logic [DW-1:0] coeff_data_i, sig_data_i;
   logic          coeff_valid_i, sig_valid_i;
   logic          coeff_ready_o, sig_ready_o;
   logic [DW-1:0] coeff_fifo_o, signal_fifo_o;
   logic          coeff_wr_o, signal_wr_o;
   logic          full_adder_i, full_mul_i;
   logic          busy_o, coeff_loaded_o, err_o;
   logic [CW-1:0] sample_cnt_o;

   always #5 clk = ~clk;

   mac_feeder #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .taps_i(taps_i),
      .stop_i(stop_i), .flush_i(flush_i),
      .coeff_data_i(coeff_data_i), .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o),
      .sig_data_i(sig_data_i), .sig_valid_i(sig_valid_i), .sig_ready_o(sig_ready_o),
      .coeff_fifo_o(coeff_fifo_o), .coeff_wr_o(coeff_wr_o), .full_adder_i(full_adder_i),
      .signal_fifo_o(signal_fifo_o), .signal_wr_o(signal_wr_o), .full_mul_i(full_mul_i),
      .busy_o(busy_o), .coeff_loaded_o(coeff_loaded_o), .sample_cnt_o(sample_cnt_o), .err_o(err_o)
   );

   // Reference model: phase 0 idle, 1 loading, 2 streaming, 3 draining.
   int          m_phase, m_taps, m_acc, m_wrn;
   bit          m_loaded, m_err;
   int unsigned m_cnt;
   logic [DW-1:0] mc[$];
   logic [DW-1:0] ms[$];

   int errors = 0;
   int checks = 0;
   bit c_acc, s_acc;
   logic [DW-1:0] cwr_log[$];
   logic [DW-1:0] swr_log[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mreset();
      m_phase = 0; m_taps = 0; m_acc = 0; m_wrn = 0;
      m_loaded = 0; m_err = 0; m_cnt = 0;
      mc.delete(); ms.delete();
   endtask

   // Called just after a falling edge with inputs already applied; returns at the next falling edge.
   task automatic step();
      bit cr, cw, sr, sw, drain_empty;
      #1;
      cr = (m_phase == 1) && (m_acc < m_taps) && !flush_i && (mc.size() == 0 || !full_adder_i);
      cw = (mc.size() != 0) && !full_adder_i;
      sr = (m_phase == 2) && !flush_i && (ms.size() == 0 || !full_mul_i);
      sw = (ms.size() != 0) && !full_mul_i;
      chk("coeff_ready", coeff_ready_o, cr);
      chk("coeff_wr", coeff_wr_o, cw);
      if (cw) chk("coeff_data", coeff_fifo_o, mc[0]);
      chk("sig_ready", sig_ready_o, sr);
      chk("signal_wr", signal_wr_o, sw);
      if (sw) chk("signal_data", signal_fifo_o, ms[0]);
      chk("busy", busy_o, m_phase != 0);
      chk("coeff_loaded", coeff_loaded_o, m_loaded);
      chk("err", err_o, m_err);
      chk("sample_cnt", sample_cnt_o, m_cnt);
      if (coeff_wr_o) cwr_log.push_back(coeff_fifo_o);
      if (signal_wr_o) swr_log.push_back(signal_fifo_o);
      c_acc = cr && coeff_valid_i;
      s_acc = sr && sig_valid_i;
      if (flush_i) begin
         mc.delete(); ms.delete();
         m_phase = 0; m_loaded = 0; m_cnt = 0;
      end else begin
         drain_empty = (ms.size() == 0);
         if (cw) void'(mc.pop_front());
         if (c_acc) mc.push_back(coeff_data_i);
         if (sw) void'(ms.pop_front());
         if (s_acc) ms.push_back(sig_data_i);
         if (sw) m_cnt = (m_cnt + 1) % 65536;
         case (m_phase)
            0: if (start_i) begin
                  m_cnt = 0;
                  if (taps_i >= 1 && taps_i <= 16) begin
                     m_phase = 1; m_taps = int'(taps_i); m_acc = 0; m_wrn = 0;
                     m_loaded = 0; m_err = 0;
                  end else m_err = 1;
               end
            1: begin
                  if (c_acc) m_acc++;
                  if (cw) m_wrn++;
                  if (m_wrn == m_taps) begin m_phase = 2; m_loaded = 1; end
               end
            2: if (stop_i) m_phase = 3;
            default: if (drain_empty) m_phase = 0;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic load(input int n, input logic [DW-1:0] base);
      int k = 0;
      int guard = 0;
      cwr_log.delete();
      taps_i = (AL+1)'(n); start_i = 1; step(); start_i = 0;
      coeff_valid_i = 1;
      while (cwr_log.size() < n && guard < 100) begin
         coeff_data_i = base + k;
         step();
         if (c_acc) k++;
         if (k >= n) coeff_valid_i = 0;
         guard++;
      end
      coeff_valid_i = 0;
      if (guard >= 100) chk("load_timeout", guard, 0);
   endtask

   initial begin
      int k, cyc;
      rstn_i = 0; start_i = 0; stop_i = 0; flush_i = 0; taps_i = '0;
      coeff_data_i = '0; sig_data_i = '0; coeff_valid_i = 0; sig_valid_i = 0;
      full_adder_i = 0; full_mul_i = 0;
      mreset();
      repeat (2) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_coeff_wr", coeff_wr_o, 0);
      chk("rst_signal_wr", signal_wr_o, 0);
      chk("rst_cnt", sample_cnt_o, 0);
      chk("rst_err", err_o, 0);
      rstn_i = 1;
      step();

      // Four coefficients back-to-back.
      load(4, 32'h11);
      chk("load4_n", cwr_log.size(), 4);
      for (int i = 0; i < 4 && i < cwr_log.size(); i++) chk("load4_word", cwr_log[i], 32'h11 + i);
      chk("load4_loaded", coeff_loaded_o, 1);

      // Eight samples with a 3-cycle full stall mid-stream.
      swr_log.delete();
      k = 0; cyc = 0;
      while (k < 8 && cyc < 40) begin
         sig_valid_i = 1; sig_data_i = 32'hA0 + k;
         full_mul_i = (cyc >= 4 && cyc < 7);
         step();
         if (s_acc) k++;
         cyc++;
      end
      sig_valid_i = 0; full_mul_i = 0;
      step(); step();
      chk("stream_cnt", sample_cnt_o, 8);
      chk("stream_n", swr_log.size(), 8);
      for (int i = 0; i < 8 && i < swr_log.size(); i++) chk("stream_word", swr_log[i], 32'hA0 + i);

      // stop together with an accepted sample while the FIFO is full.
      full_mul_i = 1; sig_valid_i = 1; sig_data_i = 32'hB0; stop_i = 1;
      step();
      stop_i = 0; sig_valid_i = 0;
      step(); step();
      full_mul_i = 0;
      cyc = 0;
      while (busy_o && cyc < 10) begin step(); cyc++; end
      chk("drain_busy", busy_o, 0);
      chk("drain_cnt", sample_cnt_o, 9);
      chk("drain_last", swr_log[$], 32'hB0);

      // Illegal then maximum tap count.
      taps_i = 0; start_i = 1; step(); start_i = 0;
      chk("taps0_err", err_o, 1);
      chk("taps0_busy", busy_o, 0);
      load(16, 32'h100);
      chk("taps16_err", err_o, 0);
      chk("taps16_n", cwr_log.size(), 16);
      chk("taps16_loaded", coeff_loaded_o, 1);

      // Return to idle, then flush partway through a load.
      stop_i = 1; step(); stop_i = 0; step(); step();
      taps_i = 8; start_i = 1; step(); start_i = 0;
      coeff_valid_i = 1; k = 0; cyc = 0;
      while (k < 2 && cyc < 10) begin coeff_data_i = 32'h300 + k; step(); if (c_acc) k++; cyc++; end
      coeff_valid_i = 0;
      flush_i = 1; step(); flush_i = 0;
      chk("flush_busy", busy_o, 0);
      chk("flush_loaded", coeff_loaded_o, 0);
      chk("flush_coeff_wr", coeff_wr_o, 0);
      load(8, 32'h200);
      chk("reload_n", cwr_log.size(), 8);
      for (int i = 0; i < 8 && i < cwr_log.size(); i++) chk("reload_word", cwr_log[i], 32'h200 + i);

      // Asynchronous reset mid-stream with a word held.
      full_mul_i = 1; sig_valid_i = 1; sig_data_i = 32'hC0;
      step();
      #2 rstn_i = 0;
      #1;
      chk("arst_signal_wr", signal_wr_o, 0);
      chk("arst_sig_ready", sig_ready_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_loaded", coeff_loaded_o, 0);
      chk("arst_cnt", sample_cnt_o, 0);
      mreset();
      @(negedge clk);
      rstn_i = 1; full_mul_i = 0;
      repeat (5) step();
      sig_valid_i = 0;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         start_i       = ($urandom_range(0, 99) < 5);
         taps_i        = (AL+1)'($urandom_range(0, 18));
         stop_i        = ($urandom_range(0, 99) < 3);
         flush_i       = ($urandom_range(0, 199) < 2);
         coeff_valid_i = ($urandom_range(0, 99) < 70);
         sig_valid_i   = ($urandom_range(0, 99) < 70);
         full_adder_i  = ($urandom_range(0, 99) < 30);
         full_mul_i    = ($urandom_range(0, 99) < 30);
         coeff_data_i  = $urandom;
         sig_data_i    = $urandom;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
